// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Function : Load/store unit for one 64-bit memory word per access. Sub-dword
//            stores use a read-modify-write sequence. Loads are sign- or
//            zero-extended. Define LSU_MISALIGN_CHECK_EN to report misaligned
//            requests through err instead of forcing them to alignment.
// Revision : 1.0  initial release
// ============================================================================
module mem_lsu (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [63:0] rdata,
   output logic [63:0] mem_a,
   output logic        mem_we,
   output logic [63:0] mem_wd,
   input  logic [63:0] mem_rd
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic        w_bad;
   logic [2:0]  w_amask;
   logic [63:0] r_addr;
   logic [1:0]  r_size;
   logic        r_sgn;
   logic [63:0] r_wdata;
   logic [63:0] r_wd;
   logic [63:0] r_rdata;
   logic [63:0] w_rsh;
   logic [63:0] w_ldata;
   logic [7:0]  w_lanes;
   logic [7:0]  w_bmask;
   logic [63:0] w_wsh;
   logic [63:0] w_merged;

   // Low address bits that must be zero for a naturally aligned access.
   always_comb begin
      w_amask = 3'b000;
      case (size)
         2'd1:    w_amask = 3'b001;
         2'd2:    w_amask = 3'b011;
         2'd3:    w_amask = 3'b111;
         default: w_amask = 3'b000;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic r_err;
   assign w_bad = |(addr[2:0] & w_amask);
   assign err   = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_bad;
      end else if (r_state == S_DONE) begin
         r_err <= 1'b0;
      end
   end
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = (r_state != S_IDLE);
      done     = 1'b0;
      mem_we   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_accept = 1'b1;
               if (w_bad) begin
                  w_next = S_DONE;
               end else if (!we) begin
                  w_next = S_LOAD;
               end else if (size == 2'd3) begin
                  w_next = S_WRITE;
               end else begin
                  w_next = S_RMW_RD;
               end
            end
         end
         S_LOAD:   w_next = S_DONE;
         S_RMW_RD: w_next = S_WRITE;
         S_WRITE: begin
            mem_we = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // Load path: bring the addressed lanes down to bit 0, then extend.
   assign w_rsh = mem_rd >> {r_addr[2:0], 3'b000};

   always_comb begin
      w_ldata = w_rsh;
      case (r_size)
         2'd0:    w_ldata = {{56{r_sgn & w_rsh[7]}},  w_rsh[7:0]};
         2'd1:    w_ldata = {{48{r_sgn & w_rsh[15]}}, w_rsh[15:0]};
         2'd2:    w_ldata = {{32{r_sgn & w_rsh[31]}}, w_rsh[31:0]};
         default: w_ldata = w_rsh;
      endcase
   end

   // Store path: byte-lane mask selects new bytes over the read-back word.
   always_comb begin
      w_lanes = 8'hFF;
      case (r_size)
         2'd0:    w_lanes = 8'h01;
         2'd1:    w_lanes = 8'h03;
         2'd2:    w_lanes = 8'h0F;
         default: w_lanes = 8'hFF;
      endcase
   end

   assign w_bmask = w_lanes << r_addr[2:0];
   assign w_wsh   = r_wdata << {r_addr[2:0], 3'b000};

   always_comb begin
      w_merged = mem_rd;
      for (int i = 0; i < 8; i++) begin
         if (w_bmask[i]) begin
            w_merged[i*8 +: 8] = w_wsh[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= 64'd0;
         r_size  <= 2'd0;
         r_sgn   <= 1'b0;
         r_wdata <= 64'd0;
         r_wd    <= 64'd0;
         r_rdata <= 64'd0;
      end else begin
         if (w_accept) begin
            r_addr  <= {addr[63:3], addr[2:0] & ~w_amask};
            r_size  <= size;
            r_sgn   <= sgn;
            r_wdata <= wdata;
            if (we && (size == 2'd3)) begin
               r_wd <= wdata;
            end
         end
         if (r_state == S_LOAD) begin
            r_rdata <= w_ldata;
         end
         if (r_state == S_RMW_RD) begin
            r_wd <= w_merged;
         end
      end
   end

   assign rdata  = r_rdata;
   assign mem_wd = r_wd;
   assign mem_a  = {r_addr[63:3], 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Function : Self-checking bench for mem_lsu with a small memory, a
//            transaction-level reference model and a per-cycle compare.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

   logic        clk;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sgn;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] rdata;
   logic [63:0] mem_a;
   logic        mem_we;
   logic [63:0] mem_wd;
   logic [63:0] mem_rd;

   mem_lsu dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .we     (we),
      .size   (size),
      .sgn    (sgn),
      .addr   (addr),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .rdata  (rdata),
      .mem_a  (mem_a),
      .mem_we (mem_we),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment memory: eight dwords, combinational read, clocked write.
   logic [63:0] bmem [0:7];
   logic [63:0] ref_mem [0:7];
   int          we_cnt = 0;

   assign mem_rd = bmem[mem_a[5:3]];

   always @(posedge clk) begin
      if (mem_we) begin
         bmem[mem_a[5:3]] <= mem_wd;
         we_cnt           <= we_cnt + 1;
      end
   end

   int          total = 0;
   int          bad   = 0;
   bit          chk_on = 1'b0;
   logic        e_busy = 1'b0;
   logic        e_done = 1'b0;
   logic        e_err  = 1'b0;
   logic        e_we   = 1'b0;
   logic [63:0] e_rdata = 64'd0;
   logic [63:0] e_a  = 64'd0;
   logic [63:0] e_wd = 64'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy",   {63'd0, busy},   {63'd0, e_busy});
         chk("done",   {63'd0, done},   {63'd0, e_done});
         chk("err",    {63'd0, err},    {63'd0, e_err});
         chk("mem_we", {63'd0, mem_we}, {63'd0, e_we});
         chk("rdata",  rdata, e_rdata);
         if (e_we) begin
            chk("mem_a",  mem_a,  e_a);
            chk("mem_wd", mem_wd, e_wd);
         end
      end
   end

   // One access from the IDLE cycle through its DONE cycle; expectations are
   // derived arithmetically from the access description.
   task automatic op(input bit w, input logic [1:0] sz, input bit sg,
                     input logic [63:0] a, input logic [63:0] wd, input bit hold);
      int          nb;
      int          off;
      int          idx;
      int          lat;
      bit          mis;
      logic [63:0] mask;
      logic [63:0] old;
      logic [63:0] v;
      logic [63:0] nw;
      nb   = 1 << sz;
      off  = int'(a[2:0]) & ~(nb - 1);
      idx  = int'(a[5:3]);
      mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
      old  = ref_mem[idx];
      v    = (old >> (8 * off)) & mask;
      if (sg && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
      nw   = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      mis  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis  = (int'(a[2:0]) & (nb - 1)) != 0;
`endif
      lat  = mis ? 1 : ((w && sz != 2'd3) ? 3 : 2);
      req = 1'b1; we = w; size = sz; sgn = sg; addr = a; wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         e_busy = 1'b1;
         e_done = (k == lat);
         e_err  = mis && (k == lat);
         e_we   = !mis && w && (k == lat - 1);
         if (e_we) begin
            e_a  = {a[63:3], 3'b000};
            e_wd = nw;
            ref_mem[idx] = nw;
         end
         if (!mis && !w && k == lat) e_rdata = v;
         if (hold && k == lat) begin
            req = 1'b1; we = 1'b1; size = 2'd3; sgn = 1'b0;
            addr = 64'h38; wdata = 64'hCAFEF00DCAFEF00D;
         end
         @(posedge clk); #1;
      end
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_we = 1'b0;
   endtask

   task automatic mem_cmp();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mem%0d", i), bmem[i], ref_mem[i]);
      end
   endtask

   initial begin
      int cnt0;
      reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0;
      addr = 64'd0; wdata = 64'd0;
      for (int i = 0; i < 8; i++) begin
         bmem[i]    = 64'h1111111111111111 * i;
         ref_mem[i] = 64'h1111111111111111 * i;
      end
      bmem[0] = 64'h8877665544332211; ref_mem[0] = 64'h8877665544332211;
      bmem[1] = 64'h00000000F0000000; ref_mem[1] = 64'h00000000F0000000;

      @(posedge clk); @(negedge clk);
      chk("rst_busy",   {63'd0, busy},   64'd0);
      chk("rst_done",   {63'd0, done},   64'd0);
      chk("rst_err",    {63'd0, err},    64'd0);
      chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("rst_rdata",  rdata,  64'd0);
      chk("rst_mem_wd", mem_wd, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_on = 1'b1;

      op(1'b0, 2'd0, 1'b1, 64'h5, 64'd0, 1'b0);
      chk("lit_lb66", rdata, 64'h0000000000000066);
      op(1'b0, 2'd2, 1'b1, 64'h8, 64'd0, 1'b0);
      chk("lit_lw_s", rdata, 64'hFFFFFFFFF0000000);
      op(1'b0, 2'd2, 1'b0, 64'h8, 64'd0, 1'b0);
      chk("lit_lw_u", rdata, 64'h00000000F0000000);
      op(1'b0, 2'd1, 1'b1, 64'h6, 64'd0, 1'b0);
      chk("lit_lh_s", rdata, 64'hFFFFFFFFFFFF8877);
      op(1'b0, 2'd3, 1'b1, 64'h0, 64'd0, 1'b0);
      chk("lit_ld", rdata, 64'h8877665544332211);

      op(1'b1, 2'd1, 1'b0, 64'h2, 64'hABCD, 1'b0);
      chk("lit_sh", bmem[0], 64'h88776655ABCD2211);
      op(1'b1, 2'd0, 1'b0, 64'h1F, 64'hFFFFFFFFFFFFFF5A, 1'b0);
      op(1'b1, 2'd2, 1'b0, 64'h0C, 64'h11223344DEADBEEF, 1'b0);
      chk("lit_sw", bmem[1], 64'hDEADBEEFF0000000);
      op(1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF, 1'b1);
      chk("lit_sd", bmem[2], 64'h0123456789ABCDEF);
      op(1'b1, 2'd3, 1'b0, 64'h38, 64'hCAFEF00DCAFEF00D, 1'b0);
      op(1'b0, 2'd0, 1'b1, 64'h3F, 64'd0, 1'b0);
      op(1'b0, 2'd2, 1'b0, 64'hE, 64'd0, 1'b0);
      op(1'b0, 2'd1, 1'b0, 64'h1B, 64'd0, 1'b0);
      mem_cmp();

      // Abort a byte store while it is reading back the target word.
      chk_on = 1'b0;
      cnt0 = we_cnt;
      req = 1'b1; we = 1'b1; size = 2'd0; sgn = 1'b0; addr = 64'h9; wdata = 64'h77;
      @(posedge clk); #1;
      req = 1'b0;
      chk("rmw_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy",   {63'd0, busy},   64'd0);
      chk("abort_mem_we", {63'd0, mem_we}, 64'd0);
      chk("abort_rdata",  rdata, 64'd0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_wr", 64'(we_cnt), 64'(cnt0));
      chk("abort_idle", {63'd0, busy}, 64'd0);
      mem_cmp();
      e_rdata = 64'd0;
      chk_on = 1'b1;

      op(1'b0, 2'd1, 1'b0, 64'h0, 64'd0, 1'b0);
      chk("lit_after_rst", rdata, 64'h0000000000002211);
`ifdef LSU_MISALIGN_CHECK_EN
      cnt0 = we_cnt;
      op(1'b0, 2'd2, 1'b0, 64'h6, 64'd0, 1'b0);
      chk("mis_rdata", rdata, 64'h0000000000002211);
      op(1'b1, 2'd1, 1'b0, 64'h3, 64'hFFFF, 1'b0);
      chk("mis_no_wr", 64'(we_cnt), 64'(cnt0));
      mem_cmp();
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
